y_pc_unit: RTL and testbench

Y_PC_UNIT -- requirements
Module: y_pc_unit

---
 rtl/y_pkg.sv | 30 +++
 rtl/y_pc_unit_if.sv | 38 +++
 rtl/y_ras.sv | 55 +++++
 rtl/y_pc_unit.sv | 150 +++++++++++++++
 tb/tb_y_pc_unit.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/y_pkg.sv
// Shared definitions for the PC unit: default widths, reset vector and the
// next-PC source encoding used by the top level and the return-address stack.
package y_pkg;

    localparam int          Y_XLEN      = 32;
    localparam logic [31:0] Y_RESET_VEC = 32'h0000_0000;
    localparam int          Y_RAS_DEPTH = 4;

    // Source of the next PC, listed highest priority first.
    typedef enum logic [2:0] {
        SEL_INT  = 3'd0,
        SEL_IRET = 3'd1,
        SEL_RET  = 3'd2,
        SEL_JMP  = 3'd3,
        SEL_BR   = 3'd4,
        SEL_HOLD = 3'd5,
        SEL_SEQ  = 3'd6
    } pc_sel_e;

    // True when the selected source counts as a normally retired instruction.
    function automatic logic sel_advances(input pc_sel_e sel);
        logic adv;
        case (sel)
            SEL_RET, SEL_JMP, SEL_BR, SEL_SEQ: adv = 1'b1;
            default:                            adv = 1'b0;
        endcase
        return adv;
    endfunction

endpackage

// File: rtl/y_pc_unit_if.sv
// Control/status bundle between the core front end and the PC unit.
// The master side drives the instruction/interrupt controls, the slave side
// (the PC unit) drives the PC state outputs.
interface y_pc_unit_if #(
    parameter int XLEN = 32
);
    logic            stall;
    logic            int_req;
    logic [XLEN-1:0] entry_point;
    logic            int_ret;
    logic            is_branch;
    logic            zero;
    logic [XLEN-1:0] branch_imm;
    logic            is_jump;
    logic [XLEN-1:0] j_imm;
    logic            call_en;
    logic            ret_en;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_p4;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] epc;
    logic            in_int;
    logic [31:0]     retired;
    logic            ras_err;

    modport master (
        output stall, int_req, entry_point, int_ret, is_branch, zero,
               branch_imm, is_jump, j_imm, call_en, ret_en,
        input  pc, pc_p4, pc_next, epc, in_int, retired, ras_err
    );

    modport slave (
        input  stall, int_req, entry_point, int_ret, is_branch, zero,
               branch_imm, is_jump, j_imm, call_en, ret_en,
        output pc, pc_p4, pc_next, epc, in_int, retired, ras_err
    );
endinterface

// File: rtl/y_ras.sv
// Circular return-address stack. A push when full overwrites the oldest
// entry; a pop when empty leaves the stack untouched. Both report o_err.
// Pop wins when push and pop are requested together.
module y_ras #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_push,
    input  logic            i_pop,
    input  logic [XLEN-1:0] i_data,
    output logic [XLEN-1:0] o_top,
    output logic            o_empty,
    output logic            o_full,
    output logic            o_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] r_stack [DEPTH];
    logic [PW-1:0]   r_ptr;
    logic [CW-1:0]   r_count;
    logic [PW-1:0]   w_ptr_inc;
    logic [PW-1:0]   w_ptr_dec;

    assign w_ptr_inc = r_ptr + PW'(1);
    assign w_ptr_dec = r_ptr - PW'(1);
    assign o_empty   = (r_count == CW'(0));
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_top     = r_stack[r_ptr];
    assign o_err     = (i_pop & o_empty) | (i_push & ~i_pop & o_full);

    // Stack storage, top pointer and occupancy; pointer wraps so the oldest entry is overwritten.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr   <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_stack[i] <= '0;
            end
        end else if (i_pop) begin
            if (!o_empty) begin
                r_ptr   <= w_ptr_dec;
                r_count <= r_count - CW'(1);
            end
        end else if (i_push) begin
            r_ptr              <= w_ptr_inc;
            r_stack[w_ptr_inc] <= i_data;
            if (!o_full) begin
                r_count <= r_count + CW'(1);
            end
        end
    end
endmodule

// File: rtl/y_pc_unit.sv
// Program counter unit: selects the next PC among interrupt entry, interrupt
// return, subroutine return, jump, taken branch, hold and sequential fetch.
// Optional return-address stack compiled in with macro Y_PC_RAS_EN; without
// it call_en/ret_en are ignored and ras_err stays 0.
module y_pc_unit
    import y_pkg::*;
#(
    parameter int              XLEN      = Y_XLEN,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(Y_RESET_VEC),
    parameter int              RAS_DEPTH = Y_RAS_DEPTH
) (
    input logic        clk,
    input logic        rst,
    y_pc_unit_if.slave bus
);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_epc;
    logic            r_in_int;
    logic [31:0]     r_retired;
    logic            r_ras_err;

    logic [XLEN-1:0] w_pc_p4;
    logic [XLEN-1:0] w_br_tgt;
    logic [XLEN-1:0] w_j_tgt;
    logic [XLEN-1:0] w_ret_tgt;
    logic [XLEN-1:0] w_low_tgt;
    logic [XLEN-1:0] w_pc_next;
    logic            w_int_take;
    logic            w_iret;
    pc_sel_e         w_sel_low;
    pc_sel_e         w_sel;

    logic            w_ret_req;
    logic [XLEN-1:0] w_ras_top;
    logic            w_ras_empty;
    logic            w_ras_err;

`ifdef Y_PC_RAS_EN
    logic w_ras_push;
    logic w_ras_pop;

    // Only a selected jump pushes and only a selected return pops, so stall-only
    // and interrupt cycles leave the stack alone.
    assign w_ret_req  = bus.ret_en;
    assign w_ras_push = (w_sel == SEL_JMP) & bus.call_en;
    assign w_ras_pop  = (w_sel == SEL_RET);

    y_ras #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_ras_push),
        .i_pop   (w_ras_pop),
        .i_data  (w_pc_p4),
        .o_top   (w_ras_top),
        .o_empty (w_ras_empty),
        .o_full  (),
        .o_err   (w_ras_err)
    );
`else
    localparam int W_UNUSED_RAS_DEPTH = RAS_DEPTH;
    logic w_unused_ras;

    assign w_ret_req    = 1'b0;
    assign w_ras_top    = '0;
    assign w_ras_empty  = 1'b1;
    assign w_ras_err    = 1'b0;
    assign w_unused_ras = ^{bus.call_en, bus.ret_en};
`endif

    // Next-PC selection: lower-priority target first (also the value saved on interrupt), then interrupt overrides.
    always_comb begin
        w_pc_p4    = r_pc + XLEN'(4);
        w_br_tgt   = (r_pc + bus.branch_imm) & ALIGN_MASK;
        w_j_tgt    = (r_pc + bus.j_imm) & ALIGN_MASK;
        w_ret_tgt  = w_ras_empty ? w_pc_p4 : (w_ras_top & ALIGN_MASK);
        w_int_take = bus.int_req & ~r_in_int;
        w_iret     = bus.int_ret & r_in_int;
        w_sel_low  = SEL_SEQ;
        w_low_tgt  = w_pc_p4;
        w_sel      = SEL_SEQ;
        w_pc_next  = w_pc_p4;

        if (w_ret_req) begin
            w_sel_low = SEL_RET;
        end else if (bus.is_jump) begin
            w_sel_low = SEL_JMP;
        end else if (bus.is_branch & bus.zero) begin
            w_sel_low = SEL_BR;
        end else if (bus.stall) begin
            w_sel_low = SEL_HOLD;
        end else begin
            w_sel_low = SEL_SEQ;
        end

        case (w_sel_low)
            SEL_RET:  w_low_tgt = w_ret_tgt;
            SEL_JMP:  w_low_tgt = w_j_tgt;
            SEL_BR:   w_low_tgt = w_br_tgt;
            SEL_HOLD: w_low_tgt = r_pc;
            default:  w_low_tgt = w_pc_p4;
        endcase

        if (w_int_take) begin
            w_sel     = SEL_INT;
            w_pc_next = bus.entry_point & ALIGN_MASK;
        end else if (w_iret) begin
            w_sel     = SEL_IRET;
            w_pc_next = r_epc;
        end else begin
            w_sel     = w_sel_low;
            w_pc_next = w_low_tgt;
        end
    end

    // PC, interrupt context, retire counter and the registered stack error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc      <= RESET_VEC & ALIGN_MASK;
            r_epc     <= '0;
            r_in_int  <= 1'b0;
            r_retired <= 32'd0;
            r_ras_err <= 1'b0;
        end else begin
            r_pc      <= w_pc_next;
            r_ras_err <= w_ras_err;
            if (w_sel == SEL_INT) begin
                r_epc    <= w_low_tgt;
                r_in_int <= 1'b1;
            end else if (w_sel == SEL_IRET) begin
                r_in_int <= 1'b0;
            end
            if (sel_advances(w_sel)) begin
                r_retired <= r_retired + 32'd1;
            end
        end
    end

    assign bus.pc      = r_pc;
    assign bus.pc_p4   = w_pc_p4;
    assign bus.pc_next = w_pc_next;
    assign bus.epc     = r_epc;
    assign bus.in_int  = r_in_int;
    assign bus.retired = r_retired;
    assign bus.ras_err = r_ras_err;
endmodule

// File: tb/tb_y_pc_unit.sv
// Self-checking bench for y_pc_unit: vector tables with expected PC state,
// a scoreboard queue between drive and check, and a hand-written
// asynchronous-reset-in-handler sequence. Follows Y_PC_RAS_EN like the RTL.
module tb_y_pc_unit;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    y_pc_unit_if #(.XLEN(32)) bus ();

    y_pc_unit #(
        .XLEN      (32),
        .RESET_VEC (32'h0000_0000),
        .RAS_DEPTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        stall;
        logic        int_req;
        logic [31:0] entry;
        logic        int_ret;
        logic        is_branch;
        logic        zero;
        logic [31:0] bimm;
        logic        is_jump;
        logic [31:0] jimm;
        logic        call_en;
        logic        ret_en;
        logic [31:0] e_pc;
        logic [31:0] e_epc;
        logic        e_in_int;
        logic [31:0] e_ret;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(
        input logic s, input logic ir, input logic [31:0] ep, input logic iret,
        input logic br, input logic z, input logic [31:0] bi,
        input logic j, input logic [31:0] ji, input logic ce, input logic re,
        input logic [31:0] pc, input logic [31:0] epc, input logic ii,
        input logic [31:0] ret, input logic err);
        vec_t v;
        v.stall = s;   v.int_req = ir; v.entry = ep;  v.int_ret = iret;
        v.is_branch = br; v.zero = z;  v.bimm = bi;
        v.is_jump = j; v.jimm = ji;    v.call_en = ce; v.ret_en = re;
        v.e_pc = pc;   v.e_epc = epc;  v.e_in_int = ii; v.e_ret = ret; v.e_err = err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.stall = 1'b0; bus.int_req = 1'b0; bus.entry_point = 32'd0; bus.int_ret = 1'b0;
        bus.is_branch = 1'b0; bus.zero = 1'b0; bus.branch_imm = 32'd0;
        bus.is_jump = 1'b0; bus.j_imm = 32'd0; bus.call_en = 1'b0; bus.ret_en = 1'b0;
    endtask

    // Called at a falling edge: drive, check pc_next, clock, then check registered state.
    task automatic apply(input vec_t v, input string tag);
        vec_t e;
        bus.stall = v.stall; bus.int_req = v.int_req; bus.entry_point = v.entry;
        bus.int_ret = v.int_ret; bus.is_branch = v.is_branch; bus.zero = v.zero;
        bus.branch_imm = v.bimm; bus.is_jump = v.is_jump; bus.j_imm = v.jimm;
        bus.call_en = v.call_en; bus.ret_en = v.ret_en;
        sb.push_back(v);
        #1;
        chk({tag, " pc_next"}, bus.pc_next, v.e_pc);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, " pc"},      bus.pc,               e.e_pc);
        chk({tag, " pc_p4"},   bus.pc_p4,            e.e_pc + 32'd4);
        chk({tag, " epc"},     bus.epc,              e.e_epc);
        chk({tag, " in_int"},  {31'd0, bus.in_int},  {31'd0, e.e_in_int});
        chk({tag, " retired"}, bus.retired,          e.e_ret);
        chk({tag, " ras_err"}, {31'd0, bus.ras_err}, {31'd0, e.e_err});
        @(negedge clk);
    endtask

    task automatic run_table(input string name);
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("%s[%0d]", name, i));
        end
        vecs.delete();
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " pc"},      bus.pc,               32'h0000_0000);
        chk({tag, " epc"},     bus.epc,              32'h0000_0000);
        chk({tag, " in_int"},  {31'd0, bus.in_int},  32'd0);
        chk({tag, " retired"}, bus.retired,          32'd0);
        chk({tag, " ras_err"}, {31'd0, bus.ras_err}, 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        clear_inputs();
        #12;
        chk_reset_state("reset");
        @(negedge clk);
        rst = 1'b0;

        //        s  ir ep            iret br z  bimm          j  jimm          ce re  pc            epc           ii ret    err
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0000_0004, 32'h0,        0, 32'd1,  0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0000_0008, 32'h0,        0, 32'd2,  0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0000_000C, 32'h0,        0, 32'd3,  0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0000_0010, 32'h0,        0, 32'd4,  0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 1, 1, 32'hFFFF_FFF8, 0, 32'h0,        0, 0, 32'h0000_0008, 32'h0,        0, 32'd5,  0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0000_000C, 32'h0,        0, 32'd6,  0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0000_0010, 32'h0,        0, 32'd7,  0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 1, 0, 32'hFFFF_FFF8, 0, 32'h0,        0, 0, 32'h0000_0014, 32'h0,        0, 32'd8,  0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h0000_000C, 0, 0, 32'h0000_0020, 32'h0,        0, 32'd9,  0));
        vecs.push_back(mk(1, 1, 32'h28,       0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0000_0028, 32'h20,       1, 32'd9,  0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0000_0020, 32'h20,       0, 32'd9,  0));
        vecs.push_back(mk(1, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0000_0020, 32'h20,       0, 32'd9,  0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h0000_0010, 0, 0, 32'h0000_0030, 32'h20,       0, 32'd10, 0));
        vecs.push_back(mk(0, 1, 32'h30,       0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0000_0030, 32'h34,       1, 32'd10, 0));
        vecs.push_back(mk(0, 1, 32'h30,       0, 0, 0, 32'h0,        1, 32'h0000_0100, 0, 0, 32'h0000_0130, 32'h34,       1, 32'd11, 0));
        vecs.push_back(mk(0, 1, 32'h30,       1, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0000_0034, 32'h34,       0, 32'd11, 0));
        vecs.push_back(mk(0, 1, 32'h201,      0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0000_0200, 32'h38,       1, 32'd11, 0));
        vecs.push_back(mk(1, 0, 32'h0,        1, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0000_0038, 32'h38,       0, 32'd11, 0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0000_003C, 32'h38,       0, 32'd12, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 1, 1, 32'h0000_0007, 0, 32'h0,        0, 0, 32'h0000_0040, 32'h38,       0, 32'd13, 0));
        vecs.push_back(mk(1, 0, 32'h0,        0, 1, 1, 32'h0000_0010, 0, 32'h0,        0, 0, 32'h0000_0050, 32'h38,       0, 32'd14, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 1, 1, 32'h0000_0100, 1, 32'h0000_0008, 0, 0, 32'h0000_0058, 32'h38,       0, 32'd15, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0, 32'h0,        1, 32'hFFFF_FFA4, 0, 0, 32'hFFFF_FFFC, 32'h38,       0, 32'd16, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0000_0000, 32'h38,       0, 32'd17, 0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 1, 1, 32'hFFFF_FFFC, 0, 32'h0,        0, 0, 32'hFFFF_FFFC, 32'h38,       0, 32'd18, 0));
        vecs.push_back(mk(1, 0, 32'h0,        0, 1, 0, 32'h0000_0040, 0, 32'h0,        0, 0, 32'hFFFF_FFFC, 32'h38,       0, 32'd18, 0));
        vecs.push_back(mk(0, 1, 32'h80,       0, 0, 0, 32'h0,        1, 32'h0000_0010, 0, 0, 32'h0000_0080, 32'h0C,       1, 32'd18, 0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0000_000C, 32'h0C,       0, 32'd18, 0));
        vecs.push_back(mk(0, 1, 32'h40,       0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0000_0040, 32'h10,       1, 32'd18, 0));
        run_table("main");

        // Reset while the handler is active: state must clear without a clock edge.
        clear_inputs();
        bus.int_req = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk_reset_state("reset_in_handler");
        @(negedge clk);
        rst = 1'b0;
        bus.int_req = 1'b0;

`ifdef Y_PC_RAS_EN
        //        s  ir ep       iret br z  bimm   j  jimm          ce re  pc            epc      ii ret    err
        vecs.push_back(mk(0, 0, 32'h0,   0, 0, 0, 32'h0, 1, 32'h0000_0100, 1, 0, 32'h0000_0100, 32'h0,   0, 32'd1,  0));
        vecs.push_back(mk(0, 0, 32'h0,   0, 0, 0, 32'h0, 1, 32'h0000_0100, 1, 0, 32'h0000_0200, 32'h0,   0, 32'd2,  0));
        vecs.push_back(mk(0, 0, 32'h0,   0, 0, 0, 32'h0, 1, 32'h0000_0100, 1, 0, 32'h0000_0300, 32'h0,   0, 32'd3,  0));
        vecs.push_back(mk(0, 0, 32'h0,   0, 0, 0, 32'h0, 1, 32'h0000_0100, 1, 0, 32'h0000_0400, 32'h0,   0, 32'd4,  0));
        vecs.push_back(mk(0, 0, 32'h0,   0, 0, 0, 32'h0, 1, 32'h0000_0100, 1, 0, 32'h0000_0500, 32'h0,   0, 32'd5,  1));
        vecs.push_back(mk(0, 0, 32'h0,   0, 0, 0, 32'h0, 0, 32'h0,        0, 1, 32'h0000_0404, 32'h0,   0, 32'd6,  0));
        vecs.push_back(mk(0, 0, 32'h0,   0, 0, 0, 32'h0, 0, 32'h0,        0, 1, 32'h0000_0304, 32'h0,   0, 32'd7,  0));
        vecs.push_back(mk(0, 0, 32'h0,   0, 0, 0, 32'h0, 0, 32'h0,        0, 1, 32'h0000_0204, 32'h0,   0, 32'd8,  0));
        vecs.push_back(mk(0, 0, 32'h0,   0, 0, 0, 32'h0, 0, 32'h0,        0, 1, 32'h0000_0104, 32'h0,   0, 32'd9,  0));
        vecs.push_back(mk(0, 0, 32'h0,   0, 0, 0, 32'h0, 0, 32'h0,        0, 1, 32'h0000_0108, 32'h0,   0, 32'd10, 1));
        vecs.push_back(mk(0, 0, 32'h0,   0, 0, 0, 32'h0, 1, 32'h0000_00F4, 1, 0, 32'h0000_01FC, 32'h0,   0, 32'd11, 0));
        vecs.push_back(mk(0, 0, 32'h0,   0, 0, 0, 32'h0, 1, 32'h0000_0100, 1, 1, 32'h0000_010C, 32'h0,   0, 32'd12, 0));
        vecs.push_back(mk(0, 0, 32'h0,   0, 0, 0, 32'h0, 0, 32'h0,        0, 1, 32'h0000_0110, 32'h0,   0, 32'd13, 1));
        vecs.push_back(mk(0, 0, 32'h0,   0, 0, 0, 32'h0, 1, 32'h0000_00F0, 1, 0, 32'h0000_0200, 32'h0,   0, 32'd14, 0));
        vecs.push_back(mk(0, 1, 32'h400, 0, 0, 0, 32'h0, 0, 32'h0,        0, 1, 32'h0000_0400, 32'h114, 1, 32'd14, 0));
        vecs.push_back(mk(0, 0, 32'h0,   1, 0, 0, 32'h0, 0, 32'h0,        0, 0, 32'h0000_0114, 32'h114, 0, 32'd14, 0));
        vecs.push_back(mk(0, 0, 32'h0,   0, 0, 0, 32'h0, 0, 32'h0,        0, 1, 32'h0000_0114, 32'h114, 0, 32'd15, 0));
        vecs.push_back(mk(0, 0, 32'h0,   0, 0, 0, 32'h0, 0, 32'h0,        0, 1, 32'h0000_0118, 32'h114, 0, 32'd16, 1));
        run_table("ras");
`else
        vecs.push_back(mk(0, 0, 32'h0,   0, 0, 0, 32'h0, 1, 32'h0000_0100, 1, 0, 32'h0000_0100, 32'h0,   0, 32'd1,  0));
        vecs.push_back(mk(0, 0, 32'h0,   0, 0, 0, 32'h0, 0, 32'h0,        0, 1, 32'h0000_0104, 32'h0,   0, 32'd2,  0));
        vecs.push_back(mk(0, 0, 32'h0,   0, 0, 0, 32'h0, 1, 32'h0000_0010, 1, 1, 32'h0000_0114, 32'h0,   0, 32'd3,  0));
        run_table("noras");
`endif

        if (sb.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
